// File: rtl/tri_bus_pkg.sv
// ----------------------------------------------------------------------------
// tri_bus_pkg
//   Shared definitions for the tri-state bus receiver:
//     - state_e     : receiver FSM encoding (IDLE / SETTLE / CAPTURE)
//     - level_width : width of a FIFO occupancy count for a given depth
//                     (one extra MSB so that "full" is distinguishable from "empty")
// ----------------------------------------------------------------------------
package tri_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tri_bus_reader_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     i_push, i_wdata write request and data; ignored when full unless a pop
//                     happens in the same cycle
//     i_pop           read request; ignored when empty
//     o_rdata         head word (0 while empty)
//     o_full/o_empty  occupancy flags
//     o_level         occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo
  import tri_bus_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_cnt;
  logic [LW-1:0]    r_rd_cnt;
  logic [LW-1:0]    w_level;
  logic             w_do_pop;
  logic             w_do_push;

  // Counters carry one bit beyond the address; the low bits index memory and
  // wrap modulo DEPTH, the difference is the occupancy.
  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign o_level   = w_level;
  assign o_empty   = (w_level == LW'(0));
  assign o_full    = (w_level == LW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? WIDTH'(0) : r_mem[r_rd_cnt[AW-1:0]];

  // Write/read counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= LW'(0);
      r_rd_cnt <= LW'(0);
    end else begin
      if (w_do_push) begin
        r_wr_cnt <= r_wr_cnt + LW'(1);
      end
      if (w_do_pop) begin
        r_rd_cnt <= r_rd_cnt + LW'(1);
      end
    end
  end

  // Storage array; content is only observable through o_rdata when non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_cnt[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/tri_bus_reader.sv
// ----------------------------------------------------------------------------
// tri_bus_reader
//   Receive end of a shared tri-state data bus. The bus and its active-low
//   enable are registered; the first SETTLE_CYC registered words of each
//   drive burst are discarded, the rest are written into a FWFT FIFO that
//   drains over a valid/ready interface.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     bus_data       bus value, meaningful while bus_en_n = 0
//     bus_en_n       remote driver enable, active low
//     out_data       FIFO head word (0 while empty)
//     out_valid      FIFO not empty
//     out_ready      consumer accepts out_data
//     level          FIFO occupancy
//     overflow       sticky: a captured word was dropped on a full FIFO
//     clr_overflow   synchronous clear of overflow (a new drop wins)
// ----------------------------------------------------------------------------
module tri_bus_reader
  import tri_bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int LW         = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_en_n,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int            CW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : CW'(0);
  localparam logic          NO_SETTLE = (SETTLE_CYC == 0);

  logic [WIDTH-1:0] r_bus_data_q;
  logic             r_en_q;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             r_overflow;

  // Input register: the enable resets to "not driving" so a reset never
  // fabricates a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_data_q <= WIDTH'(0);
      r_en_q       <= 1'b1;
    end else begin
      r_bus_data_q <= bus_data;
      r_en_q       <= bus_en_n;
    end
  end

  // FSM state and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CW'(0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and capture decision. The IDLE cycle that sees the enable
  // fall already consumes one settle word; the SETTLE cycle whose counter has
  // reached zero is the first capture, so exactly SETTLE_CYC words are skipped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_en_q) begin
          if (NO_SETTLE) begin
            w_state_nxt = ST_CAPTURE;
            w_push      = 1'b1;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = CNT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_en_q) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CW'(0)) begin
          w_state_nxt = ST_CAPTURE;
          w_push      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_CAPTURE: begin
        if (r_en_q) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_push = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CW'(0);
      end
    endcase
  end

  assign w_pop  = out_valid & out_ready;
  // A word is lost only when the FIFO is full and nothing leaves this cycle.
  assign w_drop = w_push & w_full & ~w_pop;

  // Sticky overflow flag; a fresh drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (r_bus_data_q),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid = ~w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tri_bus_reader.sv
// ----------------------------------------------------------------------------
// tb_tri_bus_reader
//   Directed bench for tri_bus_reader. dut uses SETTLE_CYC=1; dut0 uses
//   SETTLE_CYC=0 and only sees the single-cycle burst. Expected words are
//   queued when the stimulus is driven and popped when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_tri_bus_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] bus_data;
  logic             bus_en_n;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             clr_overflow;

  logic             en0_n;
  logic [WIDTH-1:0] out_data0;
  logic             out_valid0;
  logic [LW-1:0]    level0;
  logic             overflow0;

  int n_err;
  int n_chk;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_q0[$];
  logic             exp_ovf;

  tri_bus_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYC(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_data     (bus_data),
    .bus_en_n     (bus_en_n),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  tri_bus_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYC(0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_data     (bus_data),
    .bus_en_n     (en0_n),
    .out_data     (out_data0),
    .out_valid    (out_valid0),
    .out_ready    (1'b0),
    .level        (level0),
    .overflow     (overflow0),
    .clr_overflow (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a burst with words base..base+n-1 and model what gets captured.
  task automatic burst(input int n, input logic [WIDTH-1:0] base);
    bus_en_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_data = base + WIDTH'(i);
      if (i >= 1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(base + WIDTH'(i));
        else exp_ovf = 1'b1;
      end
      tick();
    end
    bus_en_n = 1'b1;
    bus_data = '0;
    tick();
    tick();
  endtask

  // Pop expected words while the DUT presents them, bounded by a cycle budget.
  task automatic drain(input string tag);
    int budget;
    budget = 40;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (out_valid) check(tag, out_data, exp_q.pop_front());
      tick();
      budget--;
    end
    out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check({tag, "_empty"}, level, 32'd0);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    exp_ovf = 1'b0;
    rst_n = 1'b1;
    bus_data = '0;
    bus_en_n = 1'b1;
    en0_n = 1'b1;
    out_ready = 1'b0;
    clr_overflow = 1'b0;

    // 1. asynchronous reset mid-cycle, release with the bus idle
    #12;
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_level", level, 32'd0);
    check("rst_ovf", overflow, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("idle_valid", out_valid, 32'd0);
    check("idle_level", level, 32'd0);

    // 2. four-word burst: first word skipped, valid three edges after first low
    bus_en_n = 1'b0;
    bus_data = 8'hA1;
    tick();
    bus_data = 8'hA2;
    exp_q.push_back(8'hA2);
    tick();
    check("lat_valid_early", out_valid, 32'd0);
    bus_data = 8'hA3;
    exp_q.push_back(8'hA3);
    tick();
    check("lat_valid", out_valid, 32'd1);
    check("lat_head", out_data, 32'hA2);
    bus_data = 8'hA4;
    exp_q.push_back(8'hA4);
    tick();
    bus_en_n = 1'b1;
    bus_data = '0;
    tick();
    tick();
    check("b4_level", level, 32'd3);
    drain("b4_data");

    // 3. seven-cycle burst into a four-entry FIFO with no consumer
    burst(7, 8'h10);
    check("ovf_level", level, 32'd4);
    check("ovf_set", overflow, 32'(exp_ovf));
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clr", overflow, 32'd0);

    // 4. full FIFO, consumer pops in the same cycle as a capture
    bus_en_n = 1'b0;
    bus_data = 8'h20;
    tick();
    bus_data = 8'h21;
    tick();
    bus_en_n = 1'b1;
    bus_data = '0;
    out_ready = 1'b1;
    check("full_pop_head", out_data, exp_q.pop_front());
    exp_q.push_back(8'h21);
    tick();
    out_ready = 1'b0;
    check("full_pp_level", level, 32'd4);
    check("full_pp_ovf", overflow, 32'd0);
    tick();
    tick();
    check("full_pp_level2", level, 32'd4);
    drain("full_pp_order");

    // 5. single-cycle burst: nothing with settle, one word without
    bus_en_n = 1'b0;
    en0_n = 1'b0;
    bus_data = 8'h5A;
    exp_q0.push_back(8'h5A);
    tick();
    bus_en_n = 1'b1;
    en0_n = 1'b1;
    bus_data = '0;
    tick();
    tick();
    tick();
    check("short_s1_level", level, 32'd0);
    check("short_s0_level", level0, 32'(exp_q0.size()));
    check("short_s0_valid", out_valid0, 32'd1);
    check("short_s0_data", out_data0, exp_q0.pop_front());

    // 6. reset during capture, bus still driven across release
    bus_en_n = 1'b0;
    bus_data = 8'h30;
    tick();
    bus_data = 8'h31;
    tick();
    bus_data = 8'h32;
    tick();
    bus_data = 8'h33;
    tick();
    check("mid_level", level, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", level, 32'd0);
    check("mid_rst_valid", out_valid, 32'd0);
    check("mid_rst_level0", level0, 32'd0);
    tick();
    rst_n = 1'b1;
    bus_data = 8'h40;
    tick();
    bus_data = 8'h41;
    exp_q.push_back(8'h41);
    tick();
    check("rel_settle_valid", out_valid, 32'd0);
    bus_data = 8'h42;
    exp_q.push_back(8'h42);
    tick();
    check("rel_cap_valid", out_valid, 32'd1);
    bus_en_n = 1'b1;
    bus_data = '0;
    tick();
    tick();
    check("rel_level", level, 32'd2);
    drain("rel_data");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
